// File: rtl/wb_pkg.sv
// Shared definitions for the RV32I writeback stage: load funct3 codes, queue entry type, defaults.
package wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int STARVE_LIMIT_DEFAULT = 2;
    localparam int LQ_DEPTH_DEFAULT     = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Load response alignment: byte/half lane select, sign/zero extension and legality check.
module wb_load_align
    import wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        legal
);

    logic [31:0] shifted;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        shifted  = rdata >> {addr_lo, 3'b000};
        byte_val = shifted[7:0];
        half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        data     = '0;
        legal    = 1'b0;
        case (funct3)
            F3_LB: begin
                data  = {{24{byte_val[7]}}, byte_val};
                legal = 1'b1;
            end
            F3_LBU: begin
                data  = {24'd0, byte_val};
                legal = 1'b1;
            end
            F3_LH: begin
                data  = {{16{half_val[15]}}, half_val};
                legal = ~addr_lo[0];
            end
            F3_LHU: begin
                data  = {16'd0, half_val};
                legal = ~addr_lo[0];
            end
            F3_LW: begin
                data  = rdata;
                legal = (addr_lo == 2'b00);
            end
            default: begin
                data  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/wb_writeback.sv
// Writeback stage: arbitrates ALU results against a small load queue into one register-file write per cycle.
// Optional forwarding ports are added when WB_BYPASS_EN is defined.
module wb_writeback
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH     = LQ_DEPTH_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    input  logic        err_clr,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        ld_overflow,
    output logic        ld_error
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]  byp_rs1_addr,
    input  logic [4:0]  byp_rs2_addr,
    output logic        byp_rs1_hit,
    output logic        byp_rs2_hit,
    output logic [31:0] byp_rs1_data,
    output logic [31:0] byp_rs2_data
`endif
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 2);

    wb_entry_t        lq_mem [LQ_DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic [SW-1:0]    starve_reg;

    logic [31:0] ld_data;
    logic        ld_legal;
    wb_entry_t   ld_entry;
    wb_entry_t   head_entry;
    logic        lq_nonempty;
    logic        alu_win;
    logic        lq_win;
    logic        lq_fits;
    logic        lq_push;
    logic        ovf_set;
    logic        err_set;

    wb_load_align u_align (
        .funct3  (ld_funct3),
        .addr_lo (ld_addr_lo),
        .rdata   (ld_rdata),
        .data    (ld_data),
        .legal   (ld_legal)
    );

    // Arbitration looks only at registered queue state, so a load is never granted in its arrival cycle.
    always_comb begin
        ld_entry    = '{rd: ld_rd, data: ld_data};
        head_entry  = lq_mem[head_reg];
        lq_nonempty = (count_reg != '0);
        alu_win     = alu_valid && (!lq_nonempty || (starve_reg == SW'(STARVE_LIMIT)));
        lq_win      = lq_nonempty && !alu_win;
        lq_fits     = ((count_reg - CNT_W'(lq_win)) < CNT_W'(LQ_DEPTH));
        lq_push     = ld_valid && ld_legal && lq_fits;
        ovf_set     = ld_valid && ld_legal && !lq_fits;
        err_set     = ld_valid && !ld_legal;
    end

    assign alu_ready = alu_win && !rst;

    // Queue storage needs no reset: a cleared count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (lq_push) begin
            lq_mem[tail_reg] <= ld_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            starve_reg  <= '0;
            wb_en       <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            ld_overflow <= 1'b0;
            ld_error    <= 1'b0;
        end else begin
            if (lq_push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (lq_win) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(lq_push) - CNT_W'(lq_win);

            if (alu_valid && lq_win) begin
                if (starve_reg != SW'(STARVE_LIMIT)) begin
                    starve_reg <= starve_reg + SW'(1);
                end
            end else begin
                starve_reg <= '0;
            end

            // Writes to x0 complete the handshake but never reach the register file.
            if (alu_win) begin
                wb_en <= (alu_rd != 5'd0);
                if (alu_rd != 5'd0) begin
                    wb_rd   <= alu_rd;
                    wb_data <= alu_data;
                end
            end else if (lq_win) begin
                wb_en <= (head_entry.rd != 5'd0);
                if (head_entry.rd != 5'd0) begin
                    wb_rd   <= head_entry.rd;
                    wb_data <= head_entry.data;
                end
            end else begin
                wb_en <= 1'b0;
            end

            ld_overflow <= ovf_set || (ld_overflow && !err_clr);
            ld_error    <= err_set || (ld_error && !err_clr);
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_rs1_hit  = wb_en && (wb_rd == byp_rs1_addr) && (byp_rs1_addr != 5'd0);
    assign byp_rs2_hit  = wb_en && (wb_rd == byp_rs2_addr) && (byp_rs2_addr != 5'd0);
    assign byp_rs1_data = byp_rs1_hit ? wb_data : 32'd0;
    assign byp_rs2_data = byp_rs2_hit ? wb_data : 32'd0;
`endif

endmodule

// File: tb/tb_wb_writeback.sv
// Self-checking bench for wb_writeback: directed literal cases plus randomized traffic against a queue-based model.
module tb_wb_writeback;
    import wb_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [2:0]  ld_funct3 = '0;
    logic [1:0]  ld_addr_lo = '0;
    logic [31:0] ld_rdata = '0;
    logic        err_clr = 1'b0;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ld_overflow;
    logic        ld_error;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_rs1_addr = '0;
    logic [4:0]  byp_rs2_addr = '0;
    logic        byp_rs1_hit;
    logic        byp_rs2_hit;
    logic [31:0] byp_rs1_data;
    logic [31:0] byp_rs2_data;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_writeback #(.LQ_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_funct3   (ld_funct3),
        .ld_addr_lo  (ld_addr_lo),
        .ld_rdata    (ld_rdata),
        .err_clr     (err_clr),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .ld_overflow (ld_overflow),
        .ld_error    (ld_error)
`ifdef WB_BYPASS_EN
        ,
        .byp_rs1_addr(byp_rs1_addr),
        .byp_rs2_addr(byp_rs2_addr),
        .byp_rs1_hit (byp_rs1_hit),
        .byp_rs2_hit (byp_rs2_hit),
        .byp_rs1_data(byp_rs1_data),
        .byp_rs2_data(byp_rs2_data)
`endif
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference load extraction from plain arithmetic on the memory word.
    function automatic bit load_ref(input logic [2:0] f3, input logic [1:0] off,
                                    input logic [31:0] w, output logic [31:0] val);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        val = 32'd0;
        case (f3)
            3'd0: begin val = (b >= 128) ? b + 32'hFFFFFF00 : b; return 1'b1; end
            3'd4: begin val = b; return 1'b1; end
            3'd1: begin val = (h >= 32768) ? h + 32'hFFFF0000 : h; return (off % 2) == 0; end
            3'd5: begin val = h; return (off % 2) == 0; end
            3'd2: begin val = w; return off == 0; end
            default: return 1'b0;
        endcase
    endfunction

    // Model state: the queue contents, starvation run length, expected registered outputs.
    wb_entry_t   mq[$];
    int          m_starve = 0;
    logic        m_en = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_data = '0;
    logic        m_ovf = 1'b0;
    logic        m_err = 1'b0;
    bit          alu_taken = 1'b0;

    always @(negedge clk) begin : model_step
        bit          aw;
        bit          lw;
        bit          ovf_set;
        bit          err_set;
        wb_entry_t   e;
        logic [31:0] v;
        if (rst) begin
            chk("rst_alu_ready", alu_ready, 0);
            chk("rst_wb_en", wb_en, 0);
            chk("rst_wb_rd", wb_rd, 0);
            chk("rst_wb_data", wb_data, 0);
            chk("rst_ld_overflow", ld_overflow, 0);
            chk("rst_ld_error", ld_error, 0);
            mq.delete();
            m_starve = 0;
            m_en = 0; m_rd = 0; m_data = 0; m_ovf = 0; m_err = 0;
            alu_taken = 0;
        end else begin
            aw = alu_valid && (mq.size() == 0 || m_starve == LIMIT);
            lw = !aw && mq.size() > 0;
            chk("alu_ready", alu_ready, aw);
            chk("wb_en", wb_en, m_en);
            chk("wb_rd", wb_rd, m_rd);
            chk("wb_data", wb_data, m_data);
            chk("ld_overflow", ld_overflow, m_ovf);
            chk("ld_error", ld_error, m_err);
`ifdef WB_BYPASS_EN
            chk("byp_rs1_hit", byp_rs1_hit, m_en && m_rd == byp_rs1_addr && byp_rs1_addr != 0);
            chk("byp_rs2_hit", byp_rs2_hit, m_en && m_rd == byp_rs2_addr && byp_rs2_addr != 0);
            chk("byp_rs1_data", byp_rs1_data, (m_en && m_rd == byp_rs1_addr && byp_rs1_addr != 0) ? m_data : 32'd0);
            chk("byp_rs2_data", byp_rs2_data, (m_en && m_rd == byp_rs2_addr && byp_rs2_addr != 0) ? m_data : 32'd0);
`endif
            alu_taken = aw;
            if (aw) begin
                m_en = (alu_rd != 0);
                if (alu_rd != 0) begin m_rd = alu_rd; m_data = alu_data; end
            end else if (lw) begin
                e = mq.pop_front();
                m_en = (e.rd != 0);
                if (e.rd != 0) begin m_rd = e.rd; m_data = e.data; end
            end else begin
                m_en = 0;
            end
            m_starve = (alu_valid && lw) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
            ovf_set = 0;
            err_set = 0;
            if (ld_valid) begin
                if (!load_ref(ld_funct3, ld_addr_lo, ld_rdata, v)) err_set = 1;
                else if (mq.size() < DEPTH) mq.push_back('{rd: ld_rd, data: v});
                else ovf_set = 1;
            end
            m_ovf = ovf_set || (m_ovf && !err_clr);
            m_err = err_set || (m_err && !err_clr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  lt_f3  [4] = '{F3_LB, F3_LB, F3_LHU, F3_LH};
    logic [1:0]  lt_off [4] = '{2'd1, 2'd2, 2'd2, 2'd2};
    logic [31:0] lt_exp [4] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000080FF, 32'hFFFF80FF};
    logic [2:0]  il_f3  [2] = '{F3_LW, 3'b011};
    logic [1:0]  il_off [2] = '{2'd1, 2'd0};
    int          st_exp [7] = '{1, 0, 0, 1, 0, 0, 1};
    logic [2:0]  f3_ok  [5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};

    initial begin
        #1_000_000;
        miscompares++;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // ALU write: ready in N, visible in N+1
        alu_valid = 1; alu_rd = 5; alu_data = 10;
        @(negedge clk); chk("alu_ready_n", alu_ready, 1);
        tick(); alu_valid = 0;
        @(negedge clk);
        chk("alu_wb_en", wb_en, 1); chk("alu_wb_rd", wb_rd, 5); chk("alu_wb_data", wb_data, 10);
        tick();

        // Aligned/extended loads appear two cycles after arrival
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_rd = 5'(i + 1); ld_funct3 = lt_f3[i]; ld_addr_lo = lt_off[i];
            ld_rdata = 32'h80FF7F01;
            tick(); ld_valid = 0;
            @(negedge clk); chk("ld_not_early", wb_en, 0);
            @(negedge clk);
            chk("ld_wb_en", wb_en, 1); chk("ld_wb_rd", wb_rd, i + 1); chk("ld_wb_data", wb_data, lt_exp[i]);
            tick();
        end

        // Illegal loads set the error flag and never write
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1; ld_rd = 9; ld_funct3 = il_f3[i]; ld_addr_lo = il_off[i];
            tick(); ld_valid = 0;
            @(negedge clk); chk("ill_ld_error", ld_error, 1);
            @(negedge clk); chk("ill_no_write", wb_en, 0);
            tick(); err_clr = 1;
            tick(); err_clr = 0;
            @(negedge clk); chk("ill_err_clr", ld_error, 0);
            tick();
        end

        // Starvation: ALU held, one load per cycle; ALU wins every third cycle, queue overflows at C6
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        ld_valid = 1; ld_rd = 3; ld_funct3 = F3_LW; ld_addr_lo = 0;
        for (int c = 0; c < 7; c++) begin
            ld_rdata = $urandom;
            @(negedge clk); chk("starve_ready", alu_ready, st_exp[c]);
            tick();
        end
        alu_valid = 0; ld_valid = 0;
        @(negedge clk); chk("starve_overflow", ld_overflow, 1);
        repeat (4) tick();
        err_clr = 1; tick(); err_clr = 0;

        // Writes to x0
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
        @(negedge clk); chk("x0_alu_ready", alu_ready, 1);
        tick(); alu_valid = 0;
        @(negedge clk); chk("x0_alu_no_write", wb_en, 0);
        ld_valid = 1; ld_rd = 0; ld_funct3 = F3_LW; ld_addr_lo = 0; ld_rdata = 32'hDEAD;
        tick(); ld_valid = 0;
        tick();
        @(negedge clk); chk("x0_ld_no_write", wb_en, 0);
        tick();

`ifdef WB_BYPASS_EN
        alu_valid = 1; alu_rd = 10; alu_data = 32'hABC;
        byp_rs1_addr = 10; byp_rs2_addr = 0;
        tick(); alu_valid = 0;
        @(negedge clk);
        chk("byp_rs1_hit_lit", byp_rs1_hit, 1); chk("byp_rs1_data_lit", byp_rs1_data, 32'hABC);
        chk("byp_rs2_hit_lit", byp_rs2_hit, 0); chk("byp_rs2_data_lit", byp_rs2_data, 0);
        tick();
`endif

        // Reset mid-operation with two queued loads and a pending ALU result
        alu_valid = 1; alu_rd = 12; alu_data = 32'h55;
        ld_valid = 1; ld_rd = 4; ld_funct3 = F3_LW; ld_addr_lo = 0; ld_rdata = 32'hCAFE;
        repeat (4) tick();
        rst = 1;
        #1;
        chk("async_rst_wb_en", wb_en, 0); chk("async_rst_wb_rd", wb_rd, 0);
        chk("async_rst_wb_data", wb_data, 0); chk("async_rst_ready", alu_ready, 0);
        alu_valid = 0; ld_valid = 0;
        tick(); tick();
        rst = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); chk("no_stale_write", wb_en, 0);
            tick();
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (!alu_valid || alu_taken) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            ld_valid   = ($urandom_range(0, 99) < 50);
            ld_rd      = 5'($urandom_range(0, 31));
            ld_funct3  = ($urandom_range(0, 99) < 85) ? f3_ok[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            ld_addr_lo = 2'($urandom_range(0, 3));
            ld_rdata   = $urandom;
            err_clr    = ($urandom_range(0, 99) < 5);
            rst        = ($urandom_range(0, 999) < 3);
`ifdef WB_BYPASS_EN
            byp_rs1_addr = ($urandom_range(0, 1) == 1) ? wb_rd : 5'($urandom_range(0, 31));
            byp_rs2_addr = 5'($urandom_range(0, 31));
`endif
            tick();
        end
        rst = 0; alu_valid = 0; ld_valid = 0; err_clr = 0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
